// File: rtl/y86_bus_memory_if.sv
// Core-side bus of the y86 memory responder: address, strobes, write data
// and the combinational read data returned by the memory.
interface y86_bus_memory_if;
  logic [31:0] bus_A;
  logic        bus_RE;
  logic        bus_WE;
  logic [31:0] bus_out;
  logic [31:0] bus_in;

  // The core drives address, strobes and store data.
  modport master (
    output bus_A,
    output bus_RE,
    output bus_WE,
    output bus_out,
    input  bus_in
  );

  // The memory answers with read data.
  modport slave (
    input  bus_A,
    input  bus_RE,
    input  bus_WE,
    input  bus_out,
    output bus_in
  );
endinterface

// File: rtl/y86_bus_memory.sv
// Byte-addressed memory for the y86 sequential core. Reads are answered in
// the same cycle. Stores go through a one-entry posted-write buffer that is
// bypassed into reads. A byte loader fills the image whenever the core is not
// storing. Read/commit counters saturate, and err latches any out-of-range
// access until reset.
module y86_bus_memory #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  y86_bus_memory_if.slave    bus,
  input  logic               ld_valid,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic [7:0]         ld_data,
  output logic               ld_ready,
  output logic [CNT_W-1:0]   rd_count,
  output logic [CNT_W-1:0]   wr_count,
  output logic               err
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0] mem [DEPTH];

  logic              pend_v;
  logic [ADDR_W-1:0] pend_addr;
  logic [31:0]       pend_data;

  // A 4-byte access is in range when its last byte sits inside the array.
  // Comparing the start address against DEPTH-4 rules out the 32-bit carry
  // case too, because no address that large passes the compare.
  logic              in_range;
  logic [ADDR_W-1:0] base;
  logic              rd_ok;
  logic              wr_ok;
  logic              bad_access;
  logic [31:0]       rd_word;

  assign in_range   = (bus.bus_A <= 32'(DEPTH - 4));
  assign base       = bus.bus_A[ADDR_W-1:0];
  assign rd_ok      = bus.bus_RE && in_range;
  assign wr_ok      = bus.bus_WE && in_range;
  assign bad_access = (bus.bus_RE || bus.bus_WE) && !in_range;

  // Byte lane gi. The offset from the pending store's base address tells
  // whether that store covers this byte, and which of its bytes to return.
  // A negative offset sets the top bit, so a byte below the pending base
  // never hits.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [ADDR_W-1:0] lane_addr;
      logic [ADDR_W:0]   lane_off;
      logic              lane_hit;

      assign lane_addr = base + ADDR_W'(gi);
      assign lane_off  = {1'b0, lane_addr} - {1'b0, pend_addr};
      assign lane_hit  = pend_v && (lane_off[ADDR_W:2] == '0);
      assign rd_word[8*gi +: 8] = lane_hit ? pend_data[{lane_off[1:0], 3'b000} +: 8]
                                           : mem[lane_addr];
    end
  endgenerate

  assign bus.bus_in = rd_ok ? rd_word : 32'd0;

  // The loader is held off while a store is in flight. The array therefore
  // has exactly one writer per edge: either the commit or the loader.
  assign ld_ready = !pend_v && !bus.bus_WE;

  // Post buffer: capture an in-range store. A new store on the commit edge
  // reloads the buffer, so back-to-back stores never stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_v    <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
    end else begin
      pend_v <= wr_ok;
      if (wr_ok) begin
        pend_addr <= base;
        pend_data <= bus.bus_out;
      end
    end
  end

  // Array write port: commit the pending store, otherwise take a loader byte.
  always_ff @(posedge clk) begin
    if (pend_v) begin
      for (int i = 0; i < 4; i++) begin
        mem[pend_addr + ADDR_W'(i)] <= pend_data[8*i +: 8];
      end
    end else if (ld_valid && ld_ready) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // Saturating statistics, plus the sticky out-of-range flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count <= '0;
      wr_count <= '0;
      err      <= 1'b0;
    end else begin
      if (rd_ok && (rd_count != '1)) rd_count <= rd_count + CNT_W'(1);
      if (pend_v && (wr_count != '1)) wr_count <= wr_count + CNT_W'(1);
      if (bad_access) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_y86_bus_memory.sv
// Scoreboard bench for y86_bus_memory. The reference model keeps the memory
// as the core sees it: every accepted store is visible from the next cycle on.
// Each cycle's expected outputs are queued when the stimulus is driven, and a
// monitor pops and compares them on the falling edge.
module tb_y86_bus_memory;
  localparam int ADDR_W = 12;
  localparam int CNT_W  = 5;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  y86_bus_memory_if bus ();
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_data;
  logic              ld_ready;
  logic [CNT_W-1:0]  rd_count;
  logic [CNT_W-1:0]  wr_count;
  logic              err;

  y86_bus_memory #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .rd_count (rd_count),
    .wr_count (wr_count),
    .err      (err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [31:0] bus_in;
    logic        ld_ready;
    int          rd;
    int          wr;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state.
  logic [7:0] view [DEPTH];
  int         rd_m = 0;
  int         wr_m = 0;
  bit         err_m = 0;
  bit         pend_m = 0;
  int         last_addr = 0;
  logic [7:0] last_old [4];
  int         txn = 0;

  function automatic bit in_rng(input logic [31:0] a);
    return ({32'd0, a} + 64'd3) < 64'(DEPTH);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, want);
    end
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk($sformatf("txn%0d bus_in", e.id), bus.bus_in, e.bus_in);
        chk($sformatf("txn%0d ld_ready", e.id), 32'(ld_ready), 32'(e.ld_ready));
        chk($sformatf("txn%0d rd_count", e.id), 32'(rd_count), 32'(e.rd));
        chk($sformatf("txn%0d wr_count", e.id), 32'(wr_count), 32'(e.wr));
        chk($sformatf("txn%0d err", e.id), 32'(err), 32'(e.err));
      end
    end
  end

  // One bus cycle. It is called just after a rising edge and returns just
  // after the next one. use_k replaces the model's read value with a
  // hand-computed constant.
  task automatic cycle(input logic [31:0] a, input bit re, input bit we,
                       input logic [31:0] wd, input bit lv,
                       input logic [ADDR_W-1:0] la, input logic [7:0] lb,
                       input bit use_k, input logic [31:0] k);
    exp_t e;
    bit   inr;
    bit   rdy;
    bus.bus_A   = a;
    bus.bus_RE  = re;
    bus.bus_WE  = we;
    bus.bus_out = wd;
    ld_valid    = lv;
    ld_addr     = la;
    ld_data     = lb;
    inr = in_rng(a);
    rdy = !pend_m && !we;
    e.id = txn;
    e.bus_in = 32'd0;
    if (re && inr)
      for (int i = 0; i < 4; i++) e.bus_in[8*i +: 8] = view[ADDR_W'(a + 32'(i))];
    if (use_k) e.bus_in = k;
    e.ld_ready = rdy;
    e.rd = rd_m;
    e.wr = wr_m;
    e.err = err_m;
    sb_q.push_back(e);
    txn++;
    // The effect of the coming rising edge.
    if (re && inr && rd_m < SAT) rd_m++;
    if ((re || we) && !inr) err_m = 1;
    if (pend_m && wr_m < SAT) wr_m++;
    if (we && inr) begin
      last_addr = int'(a);
      for (int i = 0; i < 4; i++) begin
        last_old[i] = view[ADDR_W'(a + 32'(i))];
        view[ADDR_W'(a + 32'(i))] = wd[8*i +: 8];
      end
      pend_m = 1;
    end else begin
      pend_m = 0;
    end
    if (lv && rdy) view[la] = lb;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a);
    cycle(a, 1, 0, 32'd0, 0, '0, 8'd0, 0, 32'd0);
  endtask

  task automatic rdk(input logic [31:0] a, input logic [31:0] k);
    cycle(a, 1, 0, 32'd0, 0, '0, 8'd0, 1, k);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    cycle(a, 0, 1, d, 0, '0, 8'd0, 0, 32'd0);
  endtask

  task automatic ld(input logic [ADDR_W-1:0] la, input logic [7:0] b);
    cycle(32'd0, 0, 0, 32'd0, 1, la, b, 0, 32'd0);
  endtask

  task automatic idle();
    cycle(32'd0, 0, 0, 32'd0, 0, '0, 8'd0, 0, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return 32'($urandom_range(0, 63));
    if (r < 8) return 32'($urandom_range(DEPTH - 8, DEPTH + 4));
    if (r == 8) return 32'($urandom_range(0, DEPTH - 1));
    return $urandom;
  endfunction

  // Watchdog: the bench must never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.bus_A = 32'd0;
    bus.bus_RE = 1'b0;
    bus.bus_WE = 1'b0;
    bus.bus_out = 32'd0;
    ld_valid = 1'b0;
    ld_addr = '0;
    ld_data = 8'd0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("reset bus_in", bus.bus_in, 32'd0);
    chk("reset ld_ready", 32'(ld_ready), 32'd1);
    chk("reset rd_count", 32'(rd_count), 32'd0);
    chk("reset wr_count", 32'(wr_count), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    @(posedge clk);
    #1;

    // Fill the whole image through the loader, so every later read is defined.
    for (int i = 0; i < DEPTH; i++) ld(ADDR_W'(i), 8'($urandom));

    // Load and fetch.
    ld(12'd0, 8'h89); ld(12'd1, 8'hD8); ld(12'd2, 8'h01); ld(12'd3, 8'hC0);
    rdk(32'd0, 32'hC001D889);
    idle();

    // Unaligned read.
    for (int i = 0; i < 8; i++) ld(ADDR_W'(i), 8'(i));
    ld(12'd8, 8'hAA);
    rdk(32'd5, 32'hAA070605);

    // Bypass from the pending entry, then a read served by the array.
    st(32'h10, 32'hDEADBEEF);
    rd(32'h12);
    idle();
    rdk(32'h10, 32'hDEADBEEF);

    // Back-to-back stores to one address.
    st(32'h20, 32'h11111111);
    st(32'h20, 32'h22222222);
    idle();
    rdk(32'h20, 32'h22222222);

    // Partially overlapping stores, then a read and a store in the same cycle.
    st(32'h30, 32'hA1A2A3A4);
    st(32'h32, 32'hB1B2B3B4);
    rd(32'h30);
    rd(32'h32);
    st(32'h50, 32'h01234567);
    cycle(32'h52, 1, 1, 32'h89ABCDEF, 1, 12'h60, 8'h5A, 0, 32'd0);
    idle();
    rd(32'h50);
    rd(32'h54);

    // Range boundary: the last whole word is legal; one byte past it is not.
    rd(32'hFFC);
    rdk(32'hFFD, 32'd0);
    st(32'h1000, 32'h77777777);
    rd(32'hFFC);
    rdk(32'hFFFFFFFE, 32'd0);
    st(32'hFFC, 32'h0BADF00D);
    idle();
    rdk(32'hFFC, 32'h0BADF00D);

    // Random traffic against the model; the counters reach saturation here.
    for (int n = 0; n < 3000; n++) begin
      cycle(rand_addr(), 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 4),
            $urandom, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 63)),
            8'($urandom), 0, 32'd0);
    end
    idle();

    // Reset while a store is pending: the store must never reach the array.
    st(32'h40, 32'hCAFEF00D);
    bus.bus_WE = 1'b0;
    bus.bus_RE = 1'b0;
    ld_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async rd_count", 32'(rd_count), 32'd0);
    chk("async wr_count", 32'(wr_count), 32'd0);
    chk("async err", 32'(err), 32'd0);
    chk("async ld_ready", 32'(ld_ready), 32'd1);
    rd_m = 0;
    wr_m = 0;
    err_m = 0;
    if (pend_m)
      for (int i = 0; i < 4; i++) view[ADDR_W'(last_addr + i)] = last_old[i];
    pend_m = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    rd(32'h40);
    rd(32'h40);
    idle();

    // A short random tail after reset.
    for (int n = 0; n < 200; n++) begin
      cycle(32'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
            $urandom, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 63)),
            8'($urandom), 0, 32'd0);
    end
    idle();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
